// File: rtl/response_merger_if.sv
// rtl/response_merger_if.sv - response_merger input strobes, upstream handshake and error status
interface response_merger_if #(
  parameter int SRC_WIDTH     = 8,
  parameter int PAYLOAD_WIDTH = 32
);
  logic [PAYLOAD_WIDTH-1:0] rsp_local;
  logic                     new_rsp_local;
  logic [SRC_WIDTH-1:0]     rsp_down_src;
  logic [PAYLOAD_WIDTH-1:0] rsp_down;
  logic                     new_rsp_down;
  logic [SRC_WIDTH-1:0]     rsp_up_src;
  logic [PAYLOAD_WIDTH-1:0] rsp_up;
  logic                     rsp_up_valid;
  logic                     rsp_up_ready;
  logic                     err_clear;
  logic                     ovf_local;
  logic                     ovf_down;
  logic                     hop_sat;
  logic [7:0]               drop_count;

  modport master (
    output rsp_local, new_rsp_local, rsp_down_src, rsp_down, new_rsp_down,
    output rsp_up_ready, err_clear,
    input  rsp_up_src, rsp_up, rsp_up_valid, ovf_local, ovf_down, hop_sat, drop_count
  );

  modport slave (
    input  rsp_local, new_rsp_local, rsp_down_src, rsp_down, new_rsp_down,
    input  rsp_up_ready, err_clear,
    output rsp_up_src, rsp_up, rsp_up_valid, ovf_local, ovf_down, hop_sat, drop_count
  );
endinterface

// File: rtl/response_merger.sv
// rtl/response_merger.sv - merges local and downstream responses into one upstream stream
module response_merger #(
  parameter int SRC_WIDTH     = 8,
  parameter int PAYLOAD_WIDTH = 32,
  parameter int DEPTH_LOCAL   = 4,
  parameter int DEPTH_DOWN    = 8
) (
  input logic               clock,
  input logic               reset,
  response_merger_if.slave  bus
);
  localparam int EW  = SRC_WIDTH + PAYLOAD_WIDTH;
  localparam int LAW = $clog2(DEPTH_LOCAL);
  localparam int DAW = $clog2(DEPTH_DOWN);
  localparam logic [LAW:0]           L_ONE = 1;
  localparam logic [DAW:0]           D_ONE = 1;
  localparam logic [SRC_WIDTH-1:0]   S_ONE = 1;

  logic [EW-1:0] loc_mem [DEPTH_LOCAL];
  logic [EW-1:0] down_mem [DEPTH_DOWN];

  logic [LAW:0] loc_wr_q, loc_wr_d, loc_rd_q, loc_rd_d;
  logic [DAW:0] down_wr_q, down_wr_d, down_rd_q, down_rd_d;
  logic [SRC_WIDTH-1:0]     out_src_q, out_src_d;
  logic [PAYLOAD_WIDTH-1:0] out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     rr_q, rr_d;
  logic                     ovf_local_q, ovf_local_d;
  logic                     ovf_down_q, ovf_down_d;
  logic                     hop_sat_q, hop_sat_d;
  logic [7:0]               drop_q, drop_d;

  logic loc_empty, loc_full, down_empty, down_full;
  logic load, grant_loc, grant_down;
  logic push_loc, push_down, drop_loc, drop_down, src_all_ones;
  logic [SRC_WIDTH-1:0] src_inc;
  logic [7:0] drop_base, drop_add;
  logic [8:0] drop_sum;

  assign loc_empty  = (loc_wr_q == loc_rd_q);
  assign loc_full   = (loc_wr_q[LAW] != loc_rd_q[LAW]) &&
                      (loc_wr_q[LAW-1:0] == loc_rd_q[LAW-1:0]);
  assign down_empty = (down_wr_q == down_rd_q);
  assign down_full  = (down_wr_q[DAW] != down_rd_q[DAW]) &&
                      (down_wr_q[DAW-1:0] == down_rd_q[DAW-1:0]);

  assign src_all_ones = &bus.rsp_down_src;
  assign src_inc      = src_all_ones ? bus.rsp_down_src : bus.rsp_down_src + S_ONE;

  // rr_q == 0 favours the local FIFO when both hold data
  always_comb begin
    load       = !out_valid_q || bus.rsp_up_ready;
    grant_loc  = load && !loc_empty && (down_empty || !rr_q);
    grant_down = load && !down_empty && (loc_empty || rr_q);

    // a full FIFO popped this cycle frees the slot the concurrent push needs
    push_loc  = bus.new_rsp_local && (!loc_full || grant_loc);
    drop_loc  = bus.new_rsp_local && loc_full && !grant_loc;
    push_down = bus.new_rsp_down && (!down_full || grant_down);
    drop_down = bus.new_rsp_down && down_full && !grant_down;

    loc_wr_d  = push_loc   ? loc_wr_q + L_ONE  : loc_wr_q;
    loc_rd_d  = grant_loc  ? loc_rd_q + L_ONE  : loc_rd_q;
    down_wr_d = push_down  ? down_wr_q + D_ONE : down_wr_q;
    down_rd_d = grant_down ? down_rd_q + D_ONE : down_rd_q;

    out_src_d   = out_src_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    rr_d        = rr_q;
    if (load) begin
      out_valid_d = grant_loc || grant_down;
      if (grant_loc) begin
        {out_src_d, out_data_d} = loc_mem[loc_rd_q[LAW-1:0]];
        rr_d = 1'b1;
      end else if (grant_down) begin
        {out_src_d, out_data_d} = down_mem[down_rd_q[DAW-1:0]];
        rr_d = 1'b0;
      end
    end

    ovf_local_d = (ovf_local_q && !bus.err_clear) || drop_loc;
    ovf_down_d  = (ovf_down_q && !bus.err_clear) || drop_down;
    hop_sat_d   = (hop_sat_q && !bus.err_clear) || (bus.new_rsp_down && src_all_ones);
    drop_base   = bus.err_clear ? 8'd0 : drop_q;
    drop_add    = {7'd0, drop_loc} + {7'd0, drop_down};
    drop_sum    = {1'b0, drop_base} + {1'b0, drop_add};
    drop_d      = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clock) begin
    if (push_loc)
      loc_mem[loc_wr_q[LAW-1:0]] <= {{SRC_WIDTH{1'b0}}, bus.rsp_local};
    if (push_down)
      down_mem[down_wr_q[DAW-1:0]] <= {src_inc, bus.rsp_down};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      loc_wr_q    <= '0;
      loc_rd_q    <= '0;
      down_wr_q   <= '0;
      down_rd_q   <= '0;
      out_src_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      rr_q        <= 1'b0;
      ovf_local_q <= 1'b0;
      ovf_down_q  <= 1'b0;
      hop_sat_q   <= 1'b0;
      drop_q      <= 8'd0;
    end else begin
      loc_wr_q    <= loc_wr_d;
      loc_rd_q    <= loc_rd_d;
      down_wr_q   <= down_wr_d;
      down_rd_q   <= down_rd_d;
      out_src_q   <= out_src_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      rr_q        <= rr_d;
      ovf_local_q <= ovf_local_d;
      ovf_down_q  <= ovf_down_d;
      hop_sat_q   <= hop_sat_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.rsp_up_src   = out_src_q;
  assign bus.rsp_up       = out_data_q;
  assign bus.rsp_up_valid = out_valid_q;
  assign bus.ovf_local    = ovf_local_q;
  assign bus.ovf_down     = ovf_down_q;
  assign bus.hop_sat      = hop_sat_q;
  assign bus.drop_count   = drop_q;
endmodule

// File: tb/tb_response_merger.sv
// tb/tb_response_merger.sv - self-checking bench for response_merger
module tb_response_merger;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  response_merger_if #(.SRC_WIDTH(8), .PAYLOAD_WIDTH(32)) bus ();

  response_merger #(
    .SRC_WIDTH(8), .PAYLOAD_WIDTH(32), .DEPTH_LOCAL(4), .DEPTH_DOWN(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  task automatic idle_inputs();
    bus.rsp_local     = '0;
    bus.new_rsp_local = 1'b0;
    bus.rsp_down_src  = '0;
    bus.rsp_down      = '0;
    bus.new_rsp_down  = 1'b0;
    bus.err_clear     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    idle_inputs();
    bus.rsp_up_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.rsp_up_ready = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({bus.rsp_up_valid, bus.rsp_up_src, bus.rsp_up, bus.ovf_local, bus.ovf_down,
         bus.hop_sat, bus.drop_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b src=%h rsp=%h ovf=%b%b hop=%b drop=%0d expected all 0",
               bus.rsp_up_valid, bus.rsp_up_src, bus.rsp_up, bus.ovf_local, bus.ovf_down,
               bus.hop_sat, bus.drop_count);
    end
    reset = 1'b0;
    bus.rsp_local = 32'hDEADBEEF;
    bus.new_rsp_local = 1'b1;
    bus.rsp_up_ready = 1'b1;
    @(negedge clock);
    bus.new_rsp_local = 1'b0;
    checks++;
    if (bus.rsp_up_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_cycle1: valid=%b expected 0", bus.rsp_up_valid);
    end
    @(negedge clock);
    checks++;
    if ({bus.rsp_up_valid, bus.rsp_up_src, bus.rsp_up} !== {1'b1, 8'h00, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL latency_cycle2: valid=%b src=%h rsp=%h expected 1 00 deadbeef",
               bus.rsp_up_valid, bus.rsp_up_src, bus.rsp_up);
    end
    @(negedge clock);
    checks++;
    if (bus.rsp_up_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_cycle3: valid=%b expected 0", bus.rsp_up_valid);
    end
  endtask

  task automatic test_hop();
    do_reset();
    bus.rsp_down_src = 8'd3;
    bus.rsp_down = 32'h12;
    bus.new_rsp_down = 1'b1;
    @(negedge clock);
    bus.new_rsp_down = 1'b0;
    @(negedge clock);
    checks++;
    if ({bus.rsp_up_valid, bus.rsp_up_src, bus.rsp_up, bus.hop_sat} !== {1'b1, 8'd4, 32'h12, 1'b0}) begin
      errors++;
      $display("FAIL hop_increment: valid=%b src=%h rsp=%h hop_sat=%b expected 1 04 00000012 0",
               bus.rsp_up_valid, bus.rsp_up_src, bus.rsp_up, bus.hop_sat);
    end
    bus.rsp_up_ready = 1'b1;
    bus.rsp_down_src = 8'hFF;
    bus.rsp_down = 32'h34;
    bus.new_rsp_down = 1'b1;
    @(negedge clock);
    bus.new_rsp_down = 1'b0;
    @(negedge clock);
    checks++;
    if ({bus.rsp_up_valid, bus.rsp_up_src, bus.rsp_up, bus.hop_sat} !== {1'b1, 8'hFF, 32'h34, 1'b1}) begin
      errors++;
      $display("FAIL hop_saturate: valid=%b src=%h rsp=%h hop_sat=%b expected 1 ff 00000034 1",
               bus.rsp_up_valid, bus.rsp_up_src, bus.rsp_up, bus.hop_sat);
    end
    bus.err_clear = 1'b1;
    @(negedge clock);
    bus.err_clear = 1'b0;
    checks++;
    if (bus.hop_sat !== 1'b0) begin
      errors++;
      $display("FAIL hop_clear: hop_sat=%b expected 0", bus.hop_sat);
    end
  endtask

  task automatic test_fairness();
    logic [39:0] exp_word;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.rsp_local = 32'h100 + i;
      bus.new_rsp_local = 1'b1;
      bus.rsp_down_src = 8'h10;
      bus.rsp_down = 32'h200 + i;
      bus.new_rsp_down = 1'b1;
      @(negedge clock);
    end
    idle_inputs();
    @(negedge clock);
    bus.rsp_up_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_word = (k % 2 == 0) ? {8'h00, 32'h100 + 32'(k / 2)} : {8'h11, 32'h200 + 32'(k / 2)};
      checks++;
      if ({bus.rsp_up_valid, bus.rsp_up_src, bus.rsp_up} !== {1'b1, exp_word}) begin
        errors++;
        $display("FAIL fairness_%0d: valid=%b src=%h rsp=%h expected 1 %h %h", k,
                 bus.rsp_up_valid, bus.rsp_up_src, bus.rsp_up, exp_word[39:32], exp_word[31:0]);
      end
      @(negedge clock);
    end
    checks++;
    if (bus.rsp_up_valid !== 1'b0) begin
      errors++;
      $display("FAIL fairness_drained: valid=%b expected 0", bus.rsp_up_valid);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_q[$];
    exp_q = {32'h300, 32'h301, 32'h302, 32'h303, 32'h304, 32'h306};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus.rsp_local = 32'h300 + i;
      bus.new_rsp_local = 1'b1;
      @(negedge clock);
    end
    bus.new_rsp_local = 1'b0;
    checks++;
    if ({bus.ovf_local, bus.ovf_down, bus.drop_count} !== {1'b1, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL overflow_flags: ovf_local=%b ovf_down=%b drop=%0d expected 1 0 1",
               bus.ovf_local, bus.ovf_down, bus.drop_count);
    end
    bus.rsp_local = 32'h3FF;
    bus.new_rsp_local = 1'b1;
    bus.err_clear = 1'b1;
    @(negedge clock);
    checks++;
    if ({bus.ovf_local, bus.drop_count} !== {1'b1, 8'd1}) begin
      errors++;
      $display("FAIL clear_vs_drop: ovf_local=%b drop=%0d expected 1 1", bus.ovf_local, bus.drop_count);
    end
    bus.rsp_local = 32'h306;
    bus.rsp_up_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({bus.rsp_up_valid, bus.rsp_up} !== {1'b1, exp_q[k]}) begin
        errors++;
        $display("FAIL overflow_order_%0d: valid=%b rsp=%h expected 1 %h", k,
                 bus.rsp_up_valid, bus.rsp_up, exp_q[k]);
      end
      @(negedge clock);
      if (k == 0) begin
        idle_inputs();
        checks++;
        if ({bus.ovf_local, bus.drop_count} !== {1'b0, 8'd0}) begin
          errors++;
          $display("FAIL full_push_pop: ovf_local=%b drop=%0d expected 0 0", bus.ovf_local, bus.drop_count);
        end
      end
    end
    checks++;
    if (bus.rsp_up_valid !== 1'b0) begin
      errors++;
      $display("FAIL overflow_drained: valid=%b expected 0", bus.rsp_up_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] lq[$];
    logic [39:0] dq[$];
    logic [40:0] snap;
    logic        stalled;
    logic        l_st, d_st;
    int sent, outs, lskip, dskip, ldrop, ddrop;
    sent = 0; outs = 0; lskip = 0; dskip = 0;
    stalled = 1'b0;
    snap = '0;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (stalled) begin
        checks++;
        if ({bus.rsp_up_valid, bus.rsp_up_src, bus.rsp_up} !== snap) begin
          errors++;
          $display("FAIL stall_stable: got %h expected %h", {bus.rsp_up_valid, bus.rsp_up_src, bus.rsp_up}, snap);
        end
      end
      bus.rsp_up_ready = (sent >= 100) ? 1'b1 : ($urandom_range(0, 9) < 3);
      if (bus.rsp_up_valid && bus.rsp_up_ready) begin
        outs++;
        checks++;
        if (bus.rsp_up_src == 8'h00) begin
          while (lq.size() > 0 && lq[0] != bus.rsp_up) begin
            void'(lq.pop_front());
            lskip++;
          end
          if (lq.size() == 0) begin
            errors++;
            $display("FAIL order_local: got %h expected an unsent-and-undelivered local payload", bus.rsp_up);
          end else begin
            void'(lq.pop_front());
          end
        end else begin
          while (dq.size() > 0 && dq[0] != {bus.rsp_up_src, bus.rsp_up}) begin
            void'(dq.pop_front());
            dskip++;
          end
          if (dq.size() == 0) begin
            errors++;
            $display("FAIL order_down: got %h_%h expected a pending downstream response",
                     bus.rsp_up_src, bus.rsp_up);
          end else begin
            void'(dq.pop_front());
          end
        end
      end
      stalled = bus.rsp_up_valid && !bus.rsp_up_ready;
      snap = {bus.rsp_up_valid, bus.rsp_up_src, bus.rsp_up};
      l_st = (sent < 100) && ($urandom_range(0, 1) == 1);
      d_st = (sent + (l_st ? 1 : 0) < 100) && ($urandom_range(0, 1) == 1);
      bus.new_rsp_local = l_st;
      bus.new_rsp_down  = d_st;
      if (l_st) begin
        bus.rsp_local = 32'hA000_0000 + 32'(sent);
        lq.push_back(bus.rsp_local);
        sent++;
      end
      if (d_st) begin
        bus.rsp_down_src = 8'($urandom_range(0, 254));
        bus.rsp_down = 32'hB000_0000 + 32'(sent);
        dq.push_back({bus.rsp_down_src + 8'd1, bus.rsp_down});
        sent++;
      end
      @(negedge clock);
    end
    idle_inputs();
    ldrop = lskip + lq.size();
    ddrop = dskip + dq.size();
    checks++;
    if (bus.drop_count !== 8'(ldrop + ddrop)) begin
      errors++;
      $display("FAIL bp_drop_count: got %0d expected %0d", bus.drop_count, ldrop + ddrop);
    end
    checks++;
    if (outs + int'(bus.drop_count) != 100) begin
      errors++;
      $display("FAIL bp_conservation: out+drop=%0d expected 100", outs + int'(bus.drop_count));
    end
    checks++;
    if ({bus.ovf_local, bus.ovf_down} !== {ldrop > 0, ddrop > 0}) begin
      errors++;
      $display("FAIL bp_ovf_flags: got %b%b expected %b%b", bus.ovf_local, bus.ovf_down, ldrop > 0, ddrop > 0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.rsp_local = 32'h55 + i;
      bus.new_rsp_local = 1'b1;
      @(negedge clock);
    end
    idle_inputs();
    checks++;
    if (bus.rsp_up_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: valid=%b expected 1", bus.rsp_up_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.rsp_up_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: valid=%b expected 0", bus.rsp_up_valid);
    end
    @(negedge clock);
    reset = 1'b0;
    bus.rsp_up_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checks++;
      if (bus.rsp_up_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_stale_%0d: valid=%b rsp=%h expected valid 0", k, bus.rsp_up_valid, bus.rsp_up);
      end
    end
  endtask

  initial begin
    idle_inputs();
    bus.rsp_up_ready = 1'b0;
    test_reset();
    test_hop();
    test_fairness();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
